// File: rtl/layer7_pixel_buffer_if.sv
// Pixel write-stream and FC read bus for the layer-7 pixel buffer.
// The slave modport is the buffer; the master modport is the writer/FC-engine side.
interface layer7_pixel_buffer_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 16
) ();

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              read_pixel_signal;
  logic [ADDR_W-1:0] read_row_addr;
  logic [ADDR_W-1:0] read_col_addr;
  logic [DATA_W-1:0] input_data;
  logic              addr_error;
  logic              pixel_store_done;
  logic              layer7_calculation_done;
  logic              buf_full;

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  read_pixel_signal,
    input  read_row_addr,
    input  read_col_addr,
    input  layer7_calculation_done,
    output wr_ready,
    output input_data,
    output addr_error,
    output pixel_store_done,
    output buf_full
  );

  modport master (
    output wr_valid,
    output wr_data,
    output read_pixel_signal,
    output read_row_addr,
    output read_col_addr,
    output layer7_calculation_done,
    input  wr_ready,
    input  input_data,
    input  addr_error,
    input  pixel_store_done,
    input  buf_full
  );

endinterface

// File: rtl/layer7_pixel_buffer.sv
// Feature-map buffer between layer 6 and the layer-7 FC engine: fills from a raster
// write stream, then serves registered row/col reads until the FC engine releases it.
module layer7_pixel_buffer #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  layer7_pixel_buffer_if.slave    bus_io
);

  localparam int unsigned Depth = ROWS * COLS;
  localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic [1:0] {StFill, StDone, StReady} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
  logic              wr_ready_q, wr_ready_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              addr_err_q, addr_err_d;

  logic [DATA_W-1:0] mem_q [Depth];

  logic              wr_fire;
  logic              rd_in_range;
  logic [IdxW-1:0]   rd_idx;

  assign wr_fire = bus_io.wr_valid && wr_ready_q && (state_q == StFill);

  assign rd_in_range = (bus_io.read_row_addr < ADDR_W'(ROWS)) &&
                       (bus_io.read_col_addr < ADDR_W'(COLS));
  assign rd_idx      = IdxW'(32'(bus_io.read_row_addr) * 32'(COLS) +
                             32'(bus_io.read_col_addr));

  // Fill / done / ready sequencing and the write index.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    unique case (state_q)
      StFill: begin
        if (wr_fire) begin
          if (wr_idx_q == IdxW'(Depth - 1)) begin
            wr_idx_d = '0;
            state_d  = StDone;
          end else begin
            wr_idx_d = wr_idx_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        state_d = StReady;
      end
      StReady: begin
        if (bus_io.layer7_calculation_done) begin
          state_d  = StFill;
          wr_idx_d = '0;
        end
      end
      default: begin
        state_d  = StFill;
        wr_idx_d = '0;
      end
    endcase
  end

  // Registered so wr_ready reads low while reset is held and rises one cycle later.
  assign wr_ready_d = (state_d == StFill);

  always_comb begin
    rd_data_d  = rd_data_q;
    addr_err_d = addr_err_q;
    if (bus_io.read_pixel_signal) begin
      if (rd_in_range) begin
        rd_data_d = mem_q[rd_idx];
      end else begin
        rd_data_d  = '0;
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFill;
      wr_idx_q   <= '0;
      wr_ready_q <= 1'b0;
      rd_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      wr_ready_q <= wr_ready_d;
      rd_data_q  <= rd_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Storage is not reset; a same-cycle read of this index sees the old word.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_idx_q] <= bus_io.wr_data;
    end
  end

  assign bus_io.wr_ready         = wr_ready_q;
  assign bus_io.input_data       = rd_data_q;
  assign bus_io.addr_error       = addr_err_q;
  assign bus_io.pixel_store_done = (state_q == StDone);
  assign bus_io.buf_full         = (state_q == StReady);

endmodule
